// File: rtl/mem_multiport_pkg.sv
// Shared memory definitions: default geometry, address width, FSM states.
// Imported by every memory client and by mem_multiport.
package mem_multiport_pkg;

  localparam int MEM_DEPTH_DEF  = 2048;
  localparam int MEM_WIDTH_DEF  = 8;
  localparam int WORD_WIDTH_DEF = 16;
  localparam int MEM_AW_DEF     = $clog2(MEM_DEPTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/mem_multiport_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searched upward
// from last_granted+1. Ports: req, mask, last_granted in; grant out.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int LW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic [LW-1:0]     last_granted,
  output logic [NUM_CH-1:0] grant
);

  logic [NUM_CH-1:0] elig;
  logic              found;
  int                idx;

  assign elig = req & ~mask;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_granted) + i) % NUM_CH;
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_multiport.sv
// Multi-channel byte-array memory, round-robin arbitrated, big-endian words.
// Ports: clock, nreset, req/wr_en/address/data_in per channel; ack, data_out, busy.
module mem_multiport
  import mem_multiport_pkg::*;
#(
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int MEM_WIDTH  = MEM_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int NUM_CH     = 4
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH*WORD_WIDTH-1:0] address,
  input  logic [NUM_CH*WORD_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            ack,
  output logic [WORD_WIDTH-1:0]        data_out,
  output logic                         busy
);

  localparam int BYTES = WORD_WIDTH / MEM_WIDTH;
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int LW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
  state_t                state;
  logic [LW-1:0]         last_granted;
  logic [NUM_CH-1:0]     grant;
  logic [LW-1:0]         grant_idx;
  logic [WORD_WIDTH-1:0] sel_addr;
  logic [WORD_WIDTH-1:0] sel_data;
  logic                  sel_wr;
  logic [WORD_WIDTH-1:0] rd_word;
  logic                  take;

  // Byte index of a+i, wrapped around the array.
  function automatic logic [AW-1:0] wrap(
    input logic [WORD_WIDTH-1:0] a,
    input int                    i
  );
    logic [63:0] s;
    s = 64'(a) + 64'(i);
    return AW'(s % 64'(MEM_DEPTH));
  endfunction

  // The acked channel is kept out of the running while its ack is up.
  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .LW     (LW)
  ) u_arb (
    .req          (req),
    .mask         (ack),
    .last_granted (last_granted),
    .grant        (grant)
  );

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    sel_wr    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        grant_idx = LW'(k);
        sel_addr  = address[k*WORD_WIDTH +: WORD_WIDTH];
        sel_data  = data_in[k*WORD_WIDTH +: WORD_WIDTH];
        sel_wr    = wr_en[k];
      end
    end
  end

  // Lowest address lands in the most significant byte.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      rd_word[(BYTES-1-i)*MEM_WIDTH +: MEM_WIDTH] = mem[wrap(sel_addr, i)];
    end
  end

  assign take = nreset && (state == IDLE) && (|grant);

  // Array has no reset; a write commits on its granting edge.
  always_ff @(posedge clock) begin
    if (take && sel_wr) begin
      for (int i = 0; i < BYTES; i++) begin
        mem[wrap(sel_addr, i)] <=
          sel_data[(BYTES-1-i)*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      ack          <= '0;
      data_out     <= '0;
      busy         <= 1'b0;
      last_granted <= LW'(NUM_CH - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            state        <= RESP;
            ack          <= grant;
            busy         <= 1'b1;
            last_granted <= grant_idx;
            data_out     <= sel_wr ? '0 : rd_word;
          end
        end
        RESP: begin
          state    <= IDLE;
          ack      <= '0;
          busy     <= 1'b0;
          data_out <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_multiport.md
MEM_MULTIPORT -- requirements
Module: mem_multiport

Interface
REQ-001 Parameter MEM_DEPTH, default 2048, byte locations in the array.
REQ-002 Parameter MEM_WIDTH, default 8, bits per array location.
REQ-003 Parameter WORD_WIDTH, default 16, bits per access word; SHALL be an integer multiple of MEM_WIDTH (BYTES = WORD_WIDTH/MEM_WIDTH).
REQ-004 Parameter NUM_CH, default 4, number of requesting channels, range 1..8.
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 nreset  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NUM_CH  per-channel access request, level.
REQ-008 wr_en  input  NUM_CH  per-channel write (1) / read (0) select.
REQ-009 address  input  NUM_CH*WORD_WIDTH  per-channel byte address; channel k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-010 data_in  input  NUM_CH*WORD_WIDTH  per-channel write word, packed the same way.
REQ-011 ack  output  NUM_CH  one-hot, one-cycle completion pulse to the served channel.
REQ-012 data_out  output  WORD_WIDTH  read word, valid while ack is asserted.
REQ-013 busy  output  1  high while a granted access awaits its ack.

Function
REQ-014 Two-state FSM: IDLE and RESP; IDLE with any unmasked req -> RESP; RESP -> IDLE unconditionally.
REQ-015 In IDLE, the arbiter SHALL grant exactly one requesting channel, round-robin, searching from (last_granted+1) mod NUM_CH upward.
REQ-016 Word at byte address A SHALL be {mem[A], mem[A+1], ..., mem[A+BYTES-1]}, lowest address in the most significant byte.
REQ-017 Byte addresses SHALL be taken modulo MEM_DEPTH; A+i past the last location wraps to 0.
REQ-018 A granted write SHALL update all BYTES locations at the granting edge; data_out is then 0 during its ack.
REQ-019 A granted read SHALL sample the array at the granting edge; data_out carries that word in RESP, latency one cycle from grant to ack.
REQ-020 ack[k] SHALL be high exactly for the RESP cycle following channel k's grant; all other cycles 0.
REQ-021 The channel being acked SHALL be masked from arbitration in that cycle; a requester drops req after its ack or is re-served no earlier than two cycles later.
REQ-022 Max throughput: one access per two cycles; with all NUM_CH requesting continuously, each channel is served once per 2*NUM_CH cycles.
REQ-023 Requests not granted SHALL wait without loss; address/wr_en/data_in are sampled only at the granting edge.
REQ-024 NUM_CH=1 SHALL degenerate to a plain request/ack memory with no arbitration latency penalty beyond REQ-019.

Reset
REQ-025 nreset low SHALL immediately force ack=0, data_out=0, busy=0, FSM=IDLE, last_granted=NUM_CH-1 (channel 0 highest priority first).
REQ-026 The array SHALL NOT be reset; reset asserted during RESP discards the pending ack, while a write committed at the granting edge remains.

Structure
REQ-027 MEM_DEPTH, MEM_WIDTH, WORD_WIDTH defaults and the clog2 address width SHALL live in the shared memory definitions package used by all memory clients.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, mask, last_granted; output one-hot grant), combinational, NUM_CH parametrised.
REQ-029 Array, byte packing/wrap and FSM stay in mem_multiport.

Verification
REQ-030 Reset then ch0 write 0xBEEF @0x0010, later ch0 read @0x0010 -> ack[0] one cycle after grant, data_out=0xBEEF; mem[0x10]=0xBE, mem[0x11]=0xEF.
REQ-031 Write 0x1234 @MEM_DEPTH-1 (0x07FF) -> mem[0x7FF]=0x12, mem[0x000]=0x34; read @0x07FF returns 0x1234.
REQ-032 All four channels raise read req in same cycle from reset -> acks in order ch0, ch1, ch2, ch3 at cycles 2,4,6,8 after req.
REQ-033 ch1 holds req continuously while ch2 requests once -> ch1, ch2, ch1 order, ch1 never acked in two consecutive cycles.
REQ-034 nreset pulsed low during RESP of a ch3 write -> ack stays 0, busy=0 immediately; subsequent read of that address returns the written word.
REQ-035 NUM_CH=1, WORD_WIDTH=32 instance: write 0xDEADBEEF @0x0004, read back -> 0xDEADBEEF, mem[4..7]=DE,AD,BE,EF.
